stack_unwinder: RTL
===================

STACK_UNWINDER -- requirements
Module: stack_unwinder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 18, data word width in bits.
REQ-002 The module SHALL have parameter SIZE, default 4, log2 of buffer depth; depth is 2**SIZE words.
REQ-003 The module SHALL have one clock and an asynchronous, active-high reset, with ports clk and reset.
REQ-004 Port clk: input, 1 bit, rising-edge clock.
REQ-005 Port reset: input, 1 bit, asynchronous active-high reset.
REQ-006 Port in_valid: input, 1 bit, producer has a word.
REQ-007 Port in_ready: output, 1 bit, block accepts a word this cycle.
REQ-008 Port in_data: input, WIDTH bits, pushed word.
REQ-009 Port in_last: input, 1 bit, final word of the frame.
REQ-010 Port out_valid: output, 1 bit, out_data holds a popped word.
REQ-011 Port out_ready: input, 1 bit, consumer takes the word.
REQ-012 Port out_data: output, WIDTH bits, word at top of stack.
REQ-013 Port out_last: output, 1 bit, final (bottom) word of the reversed frame.
REQ-014 Port count: output, SIZE+1 bits, words currently held.
REQ-015 Port overflow: output, 1 bit, one-cycle pulse on a forced frame end.

Function
REQ-016 The state machine SHALL have two states: FILL (push side active) and DRAIN (pop side active).
REQ-017 In FILL: in_ready=1, out_valid=0; a transfer is in_valid&&in_ready, writing in_data at index count and incrementing count.
REQ-018 An accepted word with in_last=1 SHALL end the frame: next state DRAIN.
REQ-019 Full: if an accepted word makes count=2**SIZE with in_last=0, the next state SHALL be DRAIN and overflow SHALL pulse high for exactly the following cycle.
REQ-020 In DRAIN: in_ready=0, out_valid=1, out_data=word at index count-1 (combinational from storage), out_last=(count==1).
REQ-021 A pop is out_valid&&out_ready: count decrements; the pop with count==1 SHALL return to FILL, count=0.
REQ-022 Latency: out_valid SHALL rise the cycle after the frame-ending word is accepted; in_ready SHALL rise the cycle after the last pop.
REQ-023 Order: words leave in exact reverse acceptance order; no word dropped or duplicated.
REQ-024 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 Push and pop SHALL never occur in the same cycle; input and output handshakes are mutually exclusive by state.
REQ-026 Empty frames do not exist; count is never 0 in DRAIN.
REQ-027 in_data/in_last SHALL be ignored when in_ready=0.

Reset
REQ-028 While reset=1: state FILL, count=0, in_ready=0, out_valid=0, out_last=0, overflow=0; out_data don't-care.
REQ-029 After reset deasserts, in_ready SHALL be 1 on the first clock edge.
REQ-030 Reset mid-frame (either state) SHALL discard all stored words; no partial output follows.
REQ-031 Storage contents SHALL NOT require reset.

Structure
REQ-032 The state encoding (FILL, DRAIN) SHALL live in a shared package, stack_pkg.
REQ-033 Storage SHALL be one sub-module, stack_ram: 2**SIZE x WIDTH, one synchronous write port, one asynchronous read port.
REQ-034 The control FSM and count SHALL be in stack_unwinder; count is the only pointer.

Verification (WIDTH=18, SIZE=2)
REQ-035 Reset, then push 0x15555, 0x2AAAA, 0x04444(last) -> pops 0x04444, 0x2AAAA, 0x15555; out_last only on 0x15555; count 3->0.
REQ-036 Push 4 words 0x00001..0x00004, none last -> DRAIN entered, overflow pulses one cycle, output 0x00004..0x00001.
REQ-037 DRAIN with out_ready low 5 cycles -> out_valid=1 and out_data stable; in_ready=0 despite in_valid=1.
REQ-038 Single word 0x3BBBB last -> one pop, out_last=1, in_ready=1 next cycle.
REQ-039 Assert reset after 2 pushes, then push 0x00007(last) -> only 0x00007 output.
REQ-040 Random in_valid/out_ready gaps over 200 frames -> scoreboard confirms exact reversal per frame.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared definitions for the stack unwinder: control state encoding.
package stack_pkg;

    // FILL accepts words from the producer, DRAIN hands them back in reverse.
    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/stack_ram.sv
// Stack storage: 2**SIZE x WIDTH, one synchronous write port and one
// asynchronous (combinational) read port.
module stack_ram #(
    parameter int WIDTH = 18,
    parameter int SIZE  = 4
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [SIZE-1:0]  wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [SIZE-1:0]  rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [2**SIZE];

    // Write the pushed word into its slot.
    // NOTE: the array has no reset; count alone says which slots are valid,
    // so stale contents are never observed and the array can map to plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stack_unwinder.sv
// Frame reverser: collects a frame of words, then returns them last-in
// first-out. A frame ends on in_last or when the buffer fills (overflow).
module stack_unwinder
    import stack_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int SIZE  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [SIZE:0]    count,
    output logic             overflow
);

    localparam int            DEPTH     = 2**SIZE;
    localparam logic [SIZE:0] ONE       = (SIZE+1)'(1);
    localparam logic [SIZE:0] LAST_SLOT = (SIZE+1)'(DEPTH - 1);

    state_t         state_q, state_d;
    logic [SIZE:0]  count_q, count_d;
    logic           overflow_q, overflow_d;

    logic           fill_active;
    logic           drain_active;
    logic           push;
    logic           pop;
    logic [SIZE-1:0] rd_addr;

    assign fill_active  = (state_q == FILL);
    assign drain_active = (state_q == DRAIN);

    // The handshakes use the bare state so reset never reaches a flop's D input;
    // the port-level in_ready is additionally forced low while reset is held.
    assign push = in_valid  && fill_active;
    assign pop  = out_ready && drain_active;

    assign in_ready  = fill_active && !reset;
    assign out_valid = drain_active;
    assign out_last  = drain_active && (count_q == ONE);
    assign count     = count_q;
    assign overflow  = overflow_q;

    // Top of stack is one below count; modular wrap handles count == DEPTH.
    assign rd_addr = count_q[SIZE-1:0] - SIZE'(1);

    stack_ram #(
        .WIDTH (WIDTH),
        .SIZE  (SIZE)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (count_q[SIZE-1:0]),
        .wr_data (in_data),
        .rd_addr (rd_addr),
        .rd_data (out_data)
    );

    // Next-state, count and overflow pulse decode.
    // NOTE: every signal driven here gets its hold value first so no path
    // through the case leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        overflow_d = 1'b0;
        case (state_q)
            FILL: begin
                if (push) begin
                    count_d = count_q + ONE;
                    if (in_last) begin
                        state_d = DRAIN;
                    end else if (count_q == LAST_SLOT) begin
                        state_d    = DRAIN;
                        overflow_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (pop) begin
                    count_d = count_q - ONE;
                    if (count_q == ONE) begin
                        state_d = FILL;
                        count_d = '0;
                    end
                end
            end
            default: begin
                state_d = FILL;
                count_d = '0;
            end
        endcase
    end

    // Control state register with asynchronous reset.
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FILL;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

endmodule
